// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths, limits and state encoding for the program loader
package prog_loader_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int MAX_WORDS = 4096;
  typedef enum logic [3:0] {IDLE, LEN_H, LEN_L, DAT_H, DAT_L, WRITE, CHK, DONE, ERR} state_e;
  function automatic logic len_ok(input logic [15:0] n);
    return n != 16'd0 && n <= 16'(MAX_WORDS);
  endfunction
endpackage

// File: rtl/prog_loader.sv
// prog_loader: writes a framed byte stream (length, hi/lo words, xor checksum) into the instruction RAM
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_wren_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);
  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        hi_q, hi_d, xsum_q, xsum_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              take;
  assign busy_o       = state_q inside {LEN_H, LEN_L, DAT_H, DAT_L, WRITE, CHK};
  assign byte_ready_o = state_q inside {LEN_H, LEN_L, DAT_H, DAT_L, CHK};
  assign cpu_hold_o   = busy_o | (state_q == ERR);
  assign done_o       = state_q == DONE;
  assign err_o        = state_q == ERR;
  assign ram_wren_o   = state_q == WRITE;
  assign ram_addr_o   = ram_addr_q;
  assign ram_din_o    = ram_din_q;
  assign word_count_o = wc_q;
  // abort outranks a byte offered in the same cycle, so such a byte is never consumed
  assign take = byte_valid_i & byte_ready_o & ~abort_i;
  // state and datapath registers; async reset returns every output to zero
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      n_q        <= '0;
      hi_q       <= '0;
      xsum_q     <= '0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      hi_q       <= hi_d;
      xsum_q     <= xsum_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      wc_q       <= wc_d;
    end
  // next state and datapath; the RAM port is latched on the lo byte so it holds outside WRITE
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    hi_d       = hi_q;
    xsum_d     = xsum_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    wc_d       = wc_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) begin
        state_d = LEN_H;
        wc_d    = '0;
        addr_d  = '0;
        xsum_d  = '0;
      end
      LEN_H: if (take) begin
        n_d[15:8] = byte_i;
        state_d   = LEN_L;
      end
      LEN_L: if (take) begin
        n_d[7:0] = byte_i;
        state_d  = len_ok({n_q[15:8], byte_i}) ? DAT_H : ERR;
      end
      DAT_H: if (take) begin
        hi_d    = byte_i;
        xsum_d  = xsum_q ^ byte_i;
        state_d = DAT_L;
      end
      DAT_L: if (take) begin
        ram_din_d  = {hi_q, byte_i};
        ram_addr_d = addr_q;
        xsum_d     = xsum_q ^ byte_i;
        state_d    = WRITE;
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        wc_d    = wc_q + (ADDR_W + 1)'(1);
        state_d = (16'(wc_q) + 16'd1 == n_q) ? CHK : DAT_H;
      end
      CHK: if (take) state_d = (byte_i == xsum_q) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
    if (busy_o && abort_i) state_d = ERR;
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams checked against a stream-level model of the loader
module tb_prog_loader;
  import prog_loader_pkg::*;
  logic clk = 0, rst_n = 1, start_i = 0, abort_i = 0, byte_valid_i = 0;
  logic [7:0] byte_i = 0;
  logic byte_ready_o, ram_wren_o, cpu_hold_o, busy_o, done_o, err_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_din_o;
  logic [ADDR_W:0] word_count_o;
  int checks = 0, errors = 0;
  logic [27:0] expq[$];
  logic [15:0] mem[4096];
  int pos;
  logic [15:0] n_seen;
  logic want_wren = 0, prev_wren = 0, prev_abort = 0;
  logic [7:0] q_good[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
  logic [7:0] q_bad[$]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
  logic [7:0] q_zero[$] = '{8'h00, 8'h00};
  logic [7:0] q_big[$]  = '{8'h10, 8'h01};
  logic [7:0] q_part[$] = '{8'h00, 8'h02, 8'h12};
  bit ok;
  int wc;

  prog_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_wren_o(ram_wren_o),
    .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .word_count_o(word_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // stream-level model: from the framing rules, list the writes and the final outcome
  // given how many bytes of the stream will actually be consumed
  function automatic void plan(input logic [7:0] q[$], input int avail, output bit good, output int words);
    int n = int'({q[0], q[1]});
    logic [7:0] x = 0;
    words = 0;
    good = 0;
    if (n == 0 || n > MAX_WORDS) return;
    for (int w = 0; w < n && 3 + 2 * w < avail; w++) begin
      expq.push_back({12'(w), q[2 + 2 * w], q[3 + 2 * w]});
      words++;
    end
    for (int i = 2; i < 2 + 2 * n; i++) x ^= q[i];
    good = (avail == q.size()) && (q[2 + 2 * n] == x);
  endfunction

  // per-cycle checker: write timing/content from byte positions, hold/ready relationships, reset values
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_flags", {byte_ready_o, ram_wren_o, cpu_hold_o, busy_o, done_o, err_o}, 0);
      chk("rst_ram", {ram_addr_o, ram_din_o}, 0);
      chk("rst_wc", word_count_o, 0);
      pos = 0;
      want_wren = 0;
      prev_wren = 0;
    end else begin
      chk("wren_timing", ram_wren_o, want_wren);
      chk("cpu_hold", cpu_hold_o, busy_o | err_o);
      if (ram_wren_o) begin
        chk("ready_in_write", byte_ready_o, 0);
        if (expq.size() == 0) chk("unexpected_write", {ram_addr_o, ram_din_o}, 32'hFFFFFFFF);
        else chk("write", {ram_addr_o, ram_din_o}, expq.pop_front());
        mem[ram_addr_o] = ram_din_o;
      end
      if (prev_wren && !prev_abort) chk("ready_after_write", byte_ready_o, 1);
      prev_wren = ram_wren_o;
      prev_abort = abort_i;
      want_wren = 0;
      if (start_i && !busy_o) pos = 0;
      else if (byte_valid_i && byte_ready_o && !abort_i) begin
        if (pos == 0) n_seen[15:8] = byte_i;
        if (pos == 1) n_seen[7:0] = byte_i;
        if (pos >= 3 && pos[0] && pos <= 2 * int'(n_seen) + 1) want_wren = 1;
        pos++;
      end
    end
  end

  task automatic start_load();
    @(posedge clk); #1 start_i = 1;
    @(posedge clk); #1 start_i = 0;
  endtask

  task automatic send(input logic [7:0] q[$], input bit rnd, input int abort_at, input int start_at);
    int i = 0;
    int guard = 0;
    while (i < q.size() && guard < 500) begin
      guard++;
      byte_i = q[i];
      byte_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort_i = (i == abort_at);
      start_i = (i == start_at);
      @(negedge clk);
      if (abort_i) begin
        @(posedge clk); #1;
        abort_i = 0;
        start_i = 0;
        byte_valid_i = 0;
        return;
      end
      if (byte_valid_i && byte_ready_o) i++;
      @(posedge clk); #1;
      start_i = 0;
    end
    byte_valid_i = 0;
    if (guard >= 500) chk("send_timeout", i, q.size());
  endtask

  task automatic finish_check(input string tag, input bit exp_done, input int exp_wc);
    int k = 0;
    while (!(done_o || err_o) && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk({tag, "_done"}, done_o, exp_done);
    chk({tag, "_err"}, err_o, !exp_done);
    chk({tag, "_word_count"}, word_count_o, exp_wc);
    chk({tag, "_pending_writes"}, expq.size(), 0);
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    // 1: reset mid-stream, then no consumption without start
    start_load();
    send(q_part, 0, -1, -1);
    #3 rst_n = 0;
    #1 chk("async_rst", {byte_ready_o, cpu_hold_o, busy_o, done_o, err_o, word_count_o}, 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    byte_valid_i = 1;
    byte_i = 8'h55;
    repeat (5) @(negedge clk);
    chk("idle_ready", byte_ready_o, 0);
    chk("idle_busy", busy_o, 0);
    byte_valid_i = 0;
    // 2: good two-word load
    plan(q_good, q_good.size(), ok, wc);
    start_load();
    send(q_good, 0, -1, -1);
    finish_check("good", ok, wc);
    chk("good_mem0", mem[0], 16'h1234);
    chk("good_mem1", mem[1], 16'hABCD);
    chk("good_wc_lit", word_count_o, 2);
    chk("good_hold_low", cpu_hold_o, 0);
    // 3: bad checksum
    plan(q_bad, q_bad.size(), ok, wc);
    start_load();
    send(q_bad, 0, -1, -1);
    finish_check("badchk", ok, wc);
    repeat (4) @(negedge clk);
    chk("badchk_hold", cpu_hold_o, 1);
    chk("badchk_done_lit", done_o, 0);
    // 4: illegal lengths
    plan(q_zero, q_zero.size(), ok, wc);
    start_load();
    send(q_zero, 0, -1, -1);
    finish_check("len0", ok, wc);
    plan(q_big, q_big.size(), ok, wc);
    start_load();
    send(q_big, 0, -1, -1);
    finish_check("len4097", ok, wc);
    chk("len4097_wc_lit", word_count_o, 0);
    // 5: ragged byte_valid, same contents
    mem[0] = 0;
    mem[1] = 0;
    plan(q_good, q_good.size(), ok, wc);
    start_load();
    send(q_good, 1, -1, -1);
    finish_check("ragged", ok, wc);
    chk("ragged_mem0", mem[0], 16'h1234);
    chk("ragged_mem1", mem[1], 16'hABCD);
    // 6: abort after three payload bytes, with a stray start while busy
    plan(q_good, 5, ok, wc);
    start_load();
    send(q_good, 0, 5, 3);
    chk("abort_err_now", err_o, 1);
    finish_check("abort", ok, wc);
    chk("abort_wc_lit", word_count_o, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
